datapath_unit: RTL
==================

Name: datapath_unit

Overview:
- Execution datapath directly downstream of the control unit.
- Consumes the decoded control word: D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0.
- Contains a 256x16 data memory, a 16x16 register file, a write-back mux and a 16-bit ALU.
- Executes NOOP/LOAD/STORE/ADD/SUB/HALT as sequenced by the control FSM.

Parameters:
- DATA_W, 16, datapath word width.
- RF_AW, 4, register-file address width (2**RF_AW registers).
- DM_AW, 8, data-memory address width (2**DM_AW words).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- D_addr  input  DM_AW  data-memory address.
- D_wr  input  1  data-memory write enable.
- RF_s  input  1  write-back select: 1 = memory read data, 0 = ALU result.
- RF_W_addr  input  RF_AW  register-file write address.
- RF_W_en  input  1  register-file write enable.
- RF_Ra_addr  input  RF_AW  read port A address.
- RF_Rb_addr  input  RF_AW  read port B address.
- Alu_s0  input  3  ALU function select.
- Ra_data  output  DATA_W  register-file port A value (also the memory write data).
- Rb_data  output  DATA_W  register-file port B value.
- ALU_Q  output  DATA_W  ALU result.
- D_rdata  output  DATA_W  registered data-memory read data.
- W_data  output  DATA_W  write-back mux output.

Behaviour:
- Reset asserted (Reset=0), effective immediately without a clock edge:
  - All 16 registers clear to 0, so Ra_data/Rb_data read 0.
  - D_rdata clears to 0.
  - Data-memory contents are not modified.
  - Every output is therefore 0, or a combinational function of zero registers.
- Reset release: normal operation from the first rising Clk edge with Reset=1.
- Register file:
  - Two combinational read ports and one synchronous write port.
  - On a rising edge with RF_W_en=1: reg[RF_W_addr] <= W_data.
  - Read during write to the same address: the read port shows the old value until the edge, then the new value.
- Data memory:
  - Synchronous, one-cycle read latency: D_rdata <= mem[D_addr] on every rising edge, independent of D_wr.
  - Write on a rising edge with D_wr=1: mem[D_addr] <= Ra_data.
  - Read and write to the same address on the same edge: D_rdata receives the OLD contents (read-before-write).
- LOAD timing:
  - Control presents D_addr in cycle N with RF_s=1.
  - D_rdata is valid in cycle N+1.
  - The RF write with RF_s=1, RF_W_en=1 lands in cycle N+1.
  - The register value is visible on the read ports from cycle N+2.
- Write-back mux (combinational): W_data = RF_s ? D_rdata : ALU_Q.
- ALU (combinational, A=Ra_data, B=Rb_data), selected by Alu_s0:
  - 000: 0
  - 001: A+B
  - 010: A-B
  - 011: A
  - 100: A^B
  - 101: A|B
  - 110: A&B
  - 111: A+1
- ALU arithmetic is modulo 2**DATA_W: no saturation, carry and borrow discarded.
- Register 0 is an ordinary writable register (no hard-wired zero).
- RF_W_en=1 with RF_s=1 in a cycle with no preceding memory address writes whatever D_rdata holds. This is legal, not an error.
- Reset mid-LOAD/STORE:
  - Any pending write-back is lost.
  - A STORE that has not reached its edge does not occur.
  - A memory write completed at an earlier edge persists.
- X on control inputs is never masked: D_wr and RF_W_en are used directly as enables.

Optional Feature:
- Macro: DATAPATH_FLAGS_EN
- Defined:
  - Adds outputs Z_flag, N_flag, C_flag (1 bit each), all reset to 0.
  - Flags update only on a rising edge with RF_W_en=1 and RF_s=0.
  - Z_flag = (ALU_Q==0); N_flag = ALU_Q[DATA_W-1].
  - C_flag = carry-out for 001 and 111; C_flag = borrow (A<B unsigned) for 010; C_flag = 0 otherwise.
  - Flags hold their value on all other cycles.
- Undefined: no flag ports, no flag registers; the rest of the behaviour is identical.

Test Plan:
- Reset: write regs, then pull Reset low mid-cycle -> all Ra_data/Rb_data = 0 and D_rdata = 0 before the next edge; memory word at 0x10 is unchanged after release.
- STORE/LOAD round trip:
  - Preload R1=0x1234 via the ALU path.
  - STORE Ra=1 to D_addr=0x10.
  - LOAD 0x10 -> R2: D_rdata = 0x1234 one cycle after the address, R2 = 0x1234 from the following cycle.
- ALU wrap: R3=0xFFFF, R4=0x0001.
  - ADD -> 0x0000, C_flag=1, Z_flag=1.
  - SUB R4-R3 -> 0x0002, C_flag=1.
  - Alu_s0=111 on R3 -> 0x0000.
- Same-address collisions:
  - RF write R5=0x00AA while reading R5 -> old value before the edge, 0x00AA after.
  - Memory write 0x5555 and read at 0x20 on the same edge (old word 0x1111) -> D_rdata = 0x1111, next read returns 0x5555.
- All ALU codes with A=0x00F0, B=0x0F0F -> 0, 0x0FFF, 0xF1E1, 0x00F0, 0x0FFF, 0x0FFF, 0x0000, 0x00F1.
- Reset during LOAD write-back cycle -> destination register = 0, no later spurious write.

Source files
------------

// File: rtl/datapath_unit_if.sv
// datapath_unit_if: control-word and result bundle between control unit and datapath.
// DATAPATH_FLAGS_EN adds the Z/N/C flag outputs.
interface datapath_unit_if #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4,
  parameter int DM_AW  = 8
);
  logic [DM_AW-1:0]  D_addr;
  logic              D_wr;
  logic              RF_s;
  logic [RF_AW-1:0]  RF_W_addr;
  logic              RF_W_en;
  logic [RF_AW-1:0]  RF_Ra_addr;
  logic [RF_AW-1:0]  RF_Rb_addr;
  logic [2:0]        Alu_s0;
  logic [DATA_W-1:0] Ra_data;
  logic [DATA_W-1:0] Rb_data;
  logic [DATA_W-1:0] ALU_Q;
  logic [DATA_W-1:0] D_rdata;
  logic [DATA_W-1:0] W_data;
`ifdef DATAPATH_FLAGS_EN
  logic              Z_flag;
  logic              N_flag;
  logic              C_flag;
`endif

  modport master (
    output D_addr,
    output D_wr,
    output RF_s,
    output RF_W_addr,
    output RF_W_en,
    output RF_Ra_addr,
    output RF_Rb_addr,
    output Alu_s0,
    input  Ra_data,
    input  Rb_data,
    input  ALU_Q,
    input  D_rdata,
`ifdef DATAPATH_FLAGS_EN
    input  Z_flag,
    input  N_flag,
    input  C_flag,
`endif
    input  W_data
  );

  modport slave (
    input  D_addr,
    input  D_wr,
    input  RF_s,
    input  RF_W_addr,
    input  RF_W_en,
    input  RF_Ra_addr,
    input  RF_Rb_addr,
    input  Alu_s0,
    output Ra_data,
    output Rb_data,
    output ALU_Q,
    output D_rdata,
`ifdef DATAPATH_FLAGS_EN
    output Z_flag,
    output N_flag,
    output C_flag,
`endif
    output W_data
  );
endinterface

// File: rtl/datapath_unit.sv
// datapath_unit: 16x16 RF, 256x16 data memory, write-back mux, 16-bit ALU.
// Define DATAPATH_FLAGS_EN for registered Z/N/C flags.
module datapath_unit #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4,
  parameter int DM_AW  = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  datapath_unit_if.slave bus
);
  localparam int NREG  = 2**RF_AW;
  localparam int NWORD = 2**DM_AW;

  logic [DATA_W-1:0] r_rf   [NREG];
  logic [DATA_W-1:0] r_mem  [NWORD];
  logic [DATA_W-1:0] r_drdata;
  logic [DATA_W-1:0] w_ra;
  logic [DATA_W-1:0] w_rb;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_wdata;
  logic              w_mem_we;

  assign w_ra = r_rf[bus.RF_Ra_addr];
  assign w_rb = r_rf[bus.RF_Rb_addr];

  always_comb begin
    w_alu = '0;
    unique case (bus.Alu_s0)
      3'b000: w_alu = '0;
      3'b001: w_alu = w_ra + w_rb;
      3'b010: w_alu = w_ra - w_rb;
      3'b011: w_alu = w_ra;
      3'b100: w_alu = w_ra ^ w_rb;
      3'b101: w_alu = w_ra | w_rb;
      3'b110: w_alu = w_ra & w_rb;
      3'b111: w_alu = w_ra + DATA_W'(1);
      default: w_alu = '0;
    endcase
  end

  assign w_wdata = bus.RF_s ? r_drdata : w_alu;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rf <= '{default: '0};
    end else if (bus.RF_W_en) begin
      r_rf[bus.RF_W_addr] <= w_wdata;
    end
  end

  // Memory keeps its contents through reset; a store held in reset is dropped.
  assign w_mem_we = bus.D_wr & Reset;

  always_ff @(posedge Clk) begin
    if (w_mem_we) begin
      r_mem[bus.D_addr] <= w_ra;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_drdata <= '0;
    end else begin
      r_drdata <= r_mem[bus.D_addr];
    end
  end

`ifdef DATAPATH_FLAGS_EN
  logic [DATA_W:0] w_add;
  logic [DATA_W:0] w_inc;
  logic            w_c;
  logic            r_z;
  logic            r_n;
  logic            r_c;

  assign w_add = {1'b0, w_ra} + {1'b0, w_rb};
  assign w_inc = {1'b0, w_ra} + (DATA_W+1)'(1);

  always_comb begin
    w_c = 1'b0;
    unique case (bus.Alu_s0)
      3'b001:  w_c = w_add[DATA_W];
      3'b010:  w_c = (w_ra < w_rb);
      3'b111:  w_c = w_inc[DATA_W];
      default: w_c = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_c <= 1'b0;
    end else if (bus.RF_W_en && !bus.RF_s) begin
      r_z <= (w_alu == '0);
      r_n <= w_alu[DATA_W-1];
      r_c <= w_c;
    end
  end

  assign bus.Z_flag = r_z;
  assign bus.N_flag = r_n;
  assign bus.C_flag = r_c;
`endif

  assign bus.Ra_data = w_ra;
  assign bus.Rb_data = w_rb;
  assign bus.ALU_Q   = w_alu;
  assign bus.D_rdata = r_drdata;
  assign bus.W_data  = w_wdata;
endmodule
